instr_decode_fsm: RTL and testbench



---
 rtl/instr_decode_fsm_if.sv | 29 ++
 rtl/instr_decode_fsm.sv | 152 +++++++++++++++
 tb/tb_instr_decode_fsm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_fsm_if.sv
// rtl/instr_decode_fsm_if.sv - instruction handshake and decoded control bundle
// master: instruction source / observer (drives instr_valid, instr)
// slave : decoder (drives instr_ready and all decoded controls, retired count)
interface instr_decode_fsm_if;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [7:0]  alu_op;
   logic [4:0]  muxA;
   logic [4:0]  muxB;
   logic [15:0] regs_en;
   logic [15:0] imm;
   logic        imm_control;
   logic        buff_en;
   logic        illegal;
   logic [15:0] retired;

   modport master (
      output instr_valid, instr,
      input  instr_ready, alu_op, muxA, muxB, regs_en, imm,
             imm_control, buff_en, illegal, retired
   );

   modport slave (
      input  instr_valid, instr,
      output instr_ready, alu_op, muxA, muxB, regs_en, imm,
             imm_control, buff_en, illegal, retired
   );
endinterface

// File: rtl/instr_decode_fsm.sv
// rtl/instr_decode_fsm.sv - three-state IDLE/DECODE/EXECUTE instruction decoder
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : slave side of instr_decode_fsm_if (instruction in, decoded controls out)
module instr_decode_fsm (
   input  logic                      clk,
   input  logic                      reset,
   instr_decode_fsm_if.slave         bus
);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE} state_t;

   typedef struct packed {
      logic [7:0]  alu_op;
      logic [4:0]  mux_a;
      logic [4:0]  mux_b;
      logic [15:0] imm;
      logic        imm_control;
      logic        illegal;
      logic [15:0] wr_mask;
   } dec_t;

   function automatic dec_t f_decode(input logic [15:0] w);
      dec_t       d;
      logic [3:0] op;
      logic [3:0] rd;
      logic [3:0] ext;
      logic [3:0] rs;
      logic [7:0] imm8;
      logic       rtype;
      logic       cmp;
      op    = w[15:12];
      rd    = w[11:8];
      ext   = w[7:4];
      rs    = w[3:0];
      imm8  = w[7:0];
      rtype = (op == 4'h0);
      cmp   = (op == 4'hB) || (rtype && ext == 4'hB);
      d.alu_op      = rtype ? {op, ext} : {op, 4'h0};
      d.mux_a       = {1'b0, rd};
      d.mux_b       = rtype ? {1'b0, rs} : 5'h00;
      d.imm_control = !rtype;
      if (rtype)
         d.imm = 16'h0000;
      else if (op == 4'h5 || op == 4'h9 || op == 4'hB)
         d.imm = {{8{imm8[7]}}, imm8};
      else if (op == 4'hF)
         d.imm = {imm8, 8'h00};
      else
         d.imm = {8'h00, imm8};
      d.illegal = (op == 4'h4) || (op == 4'h6) || (op == 4'h7) || (op == 4'h8);
      d.wr_mask = cmp ? 16'h0000 : (16'h0001 << rd);
      return d;
   endfunction

   state_t      r_state;
   logic [15:0] r_ir;
   logic [15:0] r_retired;
   logic        r_instr_ready;
   logic [7:0]  r_alu_op;
   logic [4:0]  r_mux_a;
   logic [4:0]  r_mux_b;
   logic [15:0] r_regs_en;
   logic [15:0] r_imm;
   logic        r_imm_control;
   logic        r_buff_en;
   logic        r_illegal;
   dec_t        w_dec;

   // In IDLE the incoming word is decoded so the fields are registered on the
   // accept edge; afterwards the latched IR feeds the decoder, so the write
   // mask taken when leaving DECODE comes from the accepted instruction.
   assign w_dec = f_decode((r_state == S_IDLE) ? bus.instr : r_ir);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_ir          <= 16'h0000;
         r_retired     <= 16'h0000;
         r_instr_ready <= 1'b1;
         r_alu_op      <= 8'h00;
         r_mux_a       <= 5'h00;
         r_mux_b       <= 5'h00;
         r_regs_en     <= 16'h0000;
         r_imm         <= 16'h0000;
         r_imm_control <= 1'b0;
         r_buff_en     <= 1'b0;
         r_illegal     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.instr_valid && r_instr_ready) begin
                  r_ir          <= bus.instr;
                  r_instr_ready <= 1'b0;
                  r_alu_op      <= w_dec.alu_op;
                  r_mux_a       <= w_dec.mux_a;
                  r_mux_b       <= w_dec.mux_b;
                  r_imm         <= w_dec.imm;
                  r_imm_control <= w_dec.imm_control;
                  r_illegal     <= w_dec.illegal;
                  r_state       <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (r_illegal) begin
                  // Undefined opcode: drop straight back to IDLE, no write.
                  r_state       <= S_IDLE;
                  r_instr_ready <= 1'b1;
                  r_alu_op      <= 8'h00;
                  r_mux_a       <= 5'h00;
                  r_mux_b       <= 5'h00;
                  r_imm         <= 16'h0000;
                  r_imm_control <= 1'b0;
                  r_illegal     <= 1'b0;
               end else begin
                  r_state   <= S_EXECUTE;
                  r_regs_en <= w_dec.wr_mask;
                  r_buff_en <= 1'b1;
               end
            end
            S_EXECUTE: begin
               r_state       <= S_IDLE;
               r_instr_ready <= 1'b1;
               r_retired     <= r_retired + 16'h0001;
               r_alu_op      <= 8'h00;
               r_mux_a       <= 5'h00;
               r_mux_b       <= 5'h00;
               r_regs_en     <= 16'h0000;
               r_imm         <= 16'h0000;
               r_imm_control <= 1'b0;
               r_buff_en     <= 1'b0;
            end
            default: begin
               r_state       <= S_IDLE;
               r_instr_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.instr_ready = r_instr_ready;
   assign bus.alu_op      = r_alu_op;
   assign bus.muxA        = r_mux_a;
   assign bus.muxB        = r_mux_b;
   assign bus.regs_en     = r_regs_en;
   assign bus.imm         = r_imm;
   assign bus.imm_control = r_imm_control;
   assign bus.buff_en     = r_buff_en;
   assign bus.illegal     = r_illegal;
   assign bus.retired     = r_retired;

endmodule

// File: tb/tb_instr_decode_fsm.sv
// tb/tb_instr_decode_fsm.sv - scoreboard testbench for instr_decode_fsm
module tb_instr_decode_fsm;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_decode_fsm_if bus ();

   instr_decode_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        illegal;
      logic [7:0]  alu_op;
      logic [4:0]  mux_a;
      logic [4:0]  mux_b;
      logic [15:0] imm;
      logic        ic;
      logic [15:0] regs_en;
      logic [15:0] retired;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [15:0] exp_retired = 16'h0000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic ill, input logic [7:0] alu, input logic [4:0] ma,
                       input logic [4:0] mb, input logic [15:0] imm, input logic ic,
                       input logic [15:0] re);
      exp_t e;
      e.illegal = ill;
      e.alu_op  = alu;
      e.mux_a   = ma;
      e.mux_b   = mb;
      e.imm     = imm;
      e.ic      = ic;
      e.regs_en = re;
      e.retired = exp_retired;
      if (!ill) exp_retired = exp_retired + 16'h0001;
      sb.push_back(e);
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the first IDLE negedge.
   task automatic issue(input logic [15:0] w, input logic ill, input logic [7:0] alu,
                        input logic [4:0] ma, input logic [4:0] mb, input logic [15:0] imm,
                        input logic ic, input logic [15:0] re);
      push(ill, alu, ma, mb, imm, ic, re);
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      if (!ill) @(negedge clk);
      @(negedge clk);
   endtask

   // Monitor: classifies each cycle from the outputs and checks against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && reset) begin
            if (bus.instr_ready) begin
               chk("idle_alu_op", 32'(bus.alu_op), 32'h0);
               chk("idle_mux", 32'({bus.muxA, bus.muxB}), 32'h0);
               chk("idle_regs_en", 32'(bus.regs_en), 32'h0);
               chk("idle_imm", 32'({bus.imm_control, bus.imm}), 32'h0);
               chk("idle_buff_illegal", 32'({bus.buff_en, bus.illegal}), 32'h0);
            end else begin
               chk("sb_has_entry", 32'(sb.size() != 0), 32'h1);
               if (sb.size() != 0) begin
                  e = sb[0];
                  if (bus.illegal || bus.buff_en) void'(sb.pop_front());
                  chk("alu_op", 32'(bus.alu_op), 32'(e.alu_op));
                  chk("muxA", 32'(bus.muxA), 32'(e.mux_a));
                  chk("muxB", 32'(bus.muxB), 32'(e.mux_b));
                  chk("imm", 32'(bus.imm), 32'(e.imm));
                  chk("imm_control", 32'(bus.imm_control), 32'(e.ic));
                  chk("retired", 32'(bus.retired), 32'(e.retired));
                  if (bus.illegal) begin
                     chk("illegal_expected", 32'(e.illegal), 32'h1);
                     chk("illegal_regs_en", 32'(bus.regs_en), 32'h0);
                     chk("illegal_buff_en", 32'(bus.buff_en), 32'h0);
                  end else if (bus.buff_en) begin
                     chk("exec_expected_legal", 32'(e.illegal), 32'h0);
                     chk("exec_regs_en", 32'(bus.regs_en), 32'(e.regs_en));
                  end else begin
                     chk("decode_regs_en", 32'(bus.regs_en), 32'h0);
                  end
               end
            end
         end
      end
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      repeat (2) @(negedge clk);

      // Reset state while reset is held low
      chk("rst_instr_ready", 32'(bus.instr_ready), 32'h1);
      chk("rst_retired", 32'(bus.retired), 32'h0);
      chk("rst_controls", 32'({bus.alu_op, bus.muxA, bus.muxB, bus.imm_control, bus.buff_en, bus.illegal}), 32'h0);
      chk("rst_regs_imm", 32'({bus.regs_en, bus.imm}), 32'h0);

      reset  = 1'b1;
      mon_en = 1'b1;

      // Legal instructions: {instr, illegal, alu_op, muxA, muxB, imm, imm_control, regs_en}
      issue(16'h0351, 1'b0, 8'h05, 5'h03, 5'h01, 16'h0000, 1'b0, 16'h0008);
      chk("retired_after_first", 32'(bus.retired), 32'h1);
      issue(16'h52FF, 1'b0, 8'h50, 5'h02, 5'h00, 16'hFFFF, 1'b1, 16'h0004);
      issue(16'hF7AB, 1'b0, 8'hF0, 5'h07, 5'h00, 16'hAB00, 1'b1, 16'h0080);
      issue(16'hB103, 1'b0, 8'hB0, 5'h01, 5'h00, 16'h0003, 1'b1, 16'h0000);
      issue(16'h0ABB, 1'b0, 8'h0B, 5'h0A, 5'h0B, 16'h0000, 1'b0, 16'h0000);
      issue(16'h9380, 1'b0, 8'h90, 5'h03, 5'h00, 16'hFF80, 1'b1, 16'h0008);
      issue(16'h1C80, 1'b0, 8'h10, 5'h0C, 5'h00, 16'h0080, 1'b1, 16'h1000);
      issue(16'hE2F0, 1'b0, 8'hE0, 5'h02, 5'h00, 16'h00F0, 1'b1, 16'h0004);
      chk("retired_after_eight", 32'(bus.retired), 32'h8);

      // Illegal opcodes: back in IDLE the cycle after DECODE, retired unchanged
      issue(16'h4123, 1'b1, 8'h40, 5'h01, 5'h00, 16'h0023, 1'b1, 16'h0000);
      chk("illegal_ready_next", 32'(bus.instr_ready), 32'h1);
      chk("illegal_retired", 32'(bus.retired), 32'h8);
      issue(16'h6000, 1'b1, 8'h60, 5'h00, 5'h00, 16'h0000, 1'b1, 16'h0000);
      issue(16'h7A5C, 1'b1, 8'h70, 5'h0A, 5'h00, 16'h005C, 1'b1, 16'h0000);
      issue(16'h8FFF, 1'b1, 8'h80, 5'h0F, 5'h00, 16'h00FF, 1'b1, 16'h0000);
      chk("retired_after_illegals", 32'(bus.retired), 32'h8);

      // instr_valid held high: exactly three accepts in nine edges
      repeat (3) push(1'b0, 8'h10, 5'h0C, 5'h00, 16'h0080, 1'b1, 16'h1000);
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h1C80;
      repeat (9) @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      chk("hold_valid_all_popped", 32'(sb.size()), 32'h0);
      chk("hold_valid_retired", 32'(bus.retired), 32'hB);

      // Wrap: preload the counter, retire two more
      force dut.r_retired = 16'hFFFE;
      #1;
      release dut.r_retired;
      exp_retired = 16'hFFFE;
      @(negedge clk);
      issue(16'h0351, 1'b0, 8'h05, 5'h03, 5'h01, 16'h0000, 1'b0, 16'h0008);
      issue(16'h52FF, 1'b0, 8'h50, 5'h02, 5'h00, 16'hFFFF, 1'b1, 16'h0004);
      chk("retired_wrap", 32'(bus.retired), 32'h0);
      issue(16'h1C80, 1'b0, 8'h10, 5'h0C, 5'h00, 16'h0080, 1'b1, 16'h1000);
      chk("retired_post_wrap", 32'(bus.retired), 32'h1);

      // Asynchronous reset in the middle of EXECUTE
      mon_en = 1'b0;
      bus.instr_valid = 1'b1;
      bus.instr       = 16'h0351;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      @(negedge clk);
      chk("abort_in_execute", 32'({bus.buff_en, bus.regs_en}), 32'h10008);
      #2 reset = 1'b0;
      #1;
      chk("abort_regs_buff", 32'({bus.buff_en, bus.regs_en}), 32'h0);
      chk("abort_retired", 32'(bus.retired), 32'h0);
      chk("abort_ready", 32'(bus.instr_ready), 32'h1);
      chk("abort_controls", 32'({bus.alu_op, bus.muxA, bus.muxB, bus.imm_control, bus.illegal}), 32'h0);
      @(negedge clk);
      chk("abort_no_strobe", 32'({bus.buff_en, bus.regs_en}), 32'h0);
      reset       = 1'b1;
      exp_retired = 16'h0000;
      mon_en      = 1'b1;

      // First edge after release accepts
      issue(16'h9380, 1'b0, 8'h90, 5'h03, 5'h00, 16'hFF80, 1'b1, 16'h0008);
      chk("retired_after_abort", 32'(bus.retired), 32'h1);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
